// File: rtl/sonar_ping_sequencer_pkg.sv
// Shared definitions for the sonar ping sequencer.
//   - default widths of the config counters and the time-of-flight result
//   - FSM state encoding
//   - ping_entry(): first active state of a ping. Zero-length BURST and BLANK
//     phases are skipped in the same transition.
package sonar_ping_sequencer_pkg;

    localparam int CNT_W_DEF = 16;
    localparam int TOF_W_DEF = 24;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BURST  = 3'd1,
        ST_BLANK  = 3'd2,
        ST_LISTEN = 3'd3,
        ST_DONE   = 3'd4,
        ST_GAP    = 3'd5
    } state_t;

    function automatic state_t ping_entry(input logic burst_zero, input logic blank_zero);
        if (!burst_zero) return ST_BURST;
        if (!blank_zero) return ST_BLANK;
        return ST_LISTEN;
    endfunction

endpackage

// File: rtl/sonar_ping_sequencer_tx_burst.sv
// Transmit burst generator for the sonar ping sequencer.
// It holds its counters cleared while inactive, so every BURST starts with
// tx high. tx toggles every half_per cycles, and a half_per of 0 counts as 1.
// burst_last flags the final cycle of the last full tx period.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   active       high while the sequencer is in BURST
//   half_per     tx half-period in cycles (latched config)
//   burst_cnt    number of full tx periods (latched config, nonzero in BURST)
//   tx           transducer drive, 0 whenever inactive
//   burst_last   last BURST cycle
module sonar_ping_sequencer_tx_burst #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic [CNT_W-1:0] half_per,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             tx,
    output logic             burst_last
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic [CNT_W-1:0] half_eff;
    logic [CNT_W-1:0] hp_cnt;
    logic [CNT_W-1:0] per_cnt;
    logic             phase;     // 0: tx high half, 1: tx low half
    logic             hp_end;

    assign half_eff   = (half_per == '0) ? ONE : half_per;
    assign hp_end     = (hp_cnt == half_eff - ONE);
    assign tx         = active && !phase;
    assign burst_last = active && hp_end && phase && (per_cnt == burst_cnt - ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_cnt  <= '0;
            per_cnt <= '0;
            phase   <= 1'b0;
        end else if (!active) begin
            hp_cnt  <= '0;
            per_cnt <= '0;
            phase   <= 1'b0;
        end else if (hp_end) begin
            hp_cnt <= '0;
            phase  <= !phase;
            if (phase) per_cnt <= per_cnt + ONE;
        end else begin
            hp_cnt <= hp_cnt + ONE;
        end
    end

endmodule

// File: rtl/sonar_ping_sequencer.sv
// Sonar ping sequencer. It runs one measurement per start_i: a transmit burst,
// then a blanking window, then a listen window. It gates and flushes the
// receive datapath and records the time of flight to the first rising edge
// of the comparator.
// Optional feature macro: PING_AUTO_REPEAT_EN. It adds auto_i/rep_gap_i and a
// GAP state that re-runs the ping from the latched config.
// Ports:
//   start_i, abort_i        ping request / forced return to IDLE (abort wins)
//   burst_cnt_i, half_per_i tx burst config (latched at start)
//   blank_i, listen_i       blanking / listen window lengths (latched at start)
//   echo_i                  comparator output, synchronous to clk
//   tx_o                    transducer drive
//   dp_en_o, dp_clr_o       datapath enable (LISTEN), flush on LISTEN entry
//   busy_o, done_o          not IDLE / 1-cycle completion pulse
//   timeout_o, tof_o        sticky result of the last completed ping
//   irq_o                   set with done_o, cleared by an accepted start
//   auto_i, rep_gap_i       (PING_AUTO_REPEAT_EN) repeat enable and gap length
module sonar_ping_sequencer
    import sonar_ping_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int TOF_W = TOF_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [CNT_W-1:0] burst_cnt_i,
    input  logic [CNT_W-1:0] half_per_i,
    input  logic [CNT_W-1:0] blank_i,
    input  logic [CNT_W-1:0] listen_i,
`ifdef PING_AUTO_REPEAT_EN
    input  logic             auto_i,
    input  logic [CNT_W-1:0] rep_gap_i,
`endif
    input  logic             echo_i,
    output logic             tx_o,
    output logic             dp_en_o,
    output logic             dp_clr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             timeout_o,
    output logic [TOF_W-1:0] tof_o,
    output logic             irq_o
);

    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W:0]   ONE_X   = (CNT_W + 1)'(1);
    localparam logic [TOF_W-1:0] TOF_ONE = TOF_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] burst_q, half_q, blank_q, listen_q;
    logic [CNT_W-1:0] cnt_q;     // cycles spent in the current state
    logic [CNT_W:0]   cnt_inc;   // cnt_q + 1 without wrap, for end-of-window compares
    logic [TOF_W-1:0] tof_q;
    logic             echo_q;
    logic             start_ok, detect, listen_end, blank_end, burst_last;
    logic             ping_entering, result_en;
`ifdef PING_AUTO_REPEAT_EN
    logic             gap_end;
`endif

    assign cnt_inc    = {1'b0, cnt_q} + ONE_X;
    assign start_ok   = (state_q == ST_IDLE) && start_i && !abort_i;
    assign detect     = (state_q == ST_LISTEN) && echo_i && !echo_q;
    // A listen length of 0 or 1 expires on the first LISTEN cycle.
    assign listen_end = (state_q == ST_LISTEN) && (cnt_inc >= {1'b0, listen_q});
    assign blank_end  = (state_q == ST_BLANK) && (cnt_inc == {1'b0, blank_q});
    assign result_en  = (state_q == ST_LISTEN) && !abort_i && (detect || listen_end);
`ifdef PING_AUTO_REPEAT_EN
    assign gap_end    = (state_q == ST_GAP) && (cnt_inc >= {1'b0, rep_gap_i});
`endif

    // The tof counter restarts on any entry into the active part of a ping.
    assign ping_entering = ((state_q == ST_IDLE) || (state_q == ST_GAP)) &&
                           (state_d inside {ST_BURST, ST_BLANK, ST_LISTEN});

    sonar_ping_sequencer_tx_burst #(.CNT_W(CNT_W)) u_tx_burst (
        .clk        (clk),
        .rst_n      (rst_n),
        .active     (state_q == ST_BURST),
        .half_per   (half_q),
        .burst_cnt  (burst_q),
        .tx         (tx_o),
        .burst_last (burst_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                // Skip decisions use the inputs directly because they are latched on this edge.
                if (start_ok) state_d = ping_entry(burst_cnt_i == '0, blank_i == '0);
            end
            ST_BURST: begin
                if (burst_last) state_d = (blank_q == '0) ? ST_LISTEN : ST_BLANK;
            end
            ST_BLANK: begin
                if (blank_end) state_d = ST_LISTEN;
            end
            ST_LISTEN: begin
                if (detect || listen_end) state_d = ST_DONE;
            end
            ST_DONE: begin
`ifdef PING_AUTO_REPEAT_EN
                state_d = auto_i ? ST_GAP : ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_GAP: begin
`ifdef PING_AUTO_REPEAT_EN
                if (!auto_i)      state_d = ST_IDLE;
                else if (gap_end) state_d = ping_entry(burst_q == '0, blank_q == '0);
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        if (abort_i) state_d = ST_IDLE;
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign dp_en_o  = (state_q == ST_LISTEN);
    assign dp_clr_o = (state_q == ST_LISTEN) && (cnt_q == '0);
    assign done_o   = (state_q == ST_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            tof_q     <= '0;
            echo_q    <= 1'b0;
            tof_o     <= '0;
            timeout_o <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            state_q <= state_d;
            echo_q  <= echo_i;

            if (state_d != state_q)       cnt_q <= '0;
            else if (state_q != ST_IDLE)  cnt_q <= cnt_q + ONE;

            if (ping_entering)                  tof_q <= '0;
            else if (busy_o && (tof_q != '1))   tof_q <= tof_q + TOF_ONE;

            if (start_ok) irq_o <= 1'b0;

            // Detect takes priority over expiry in the same cycle.
            if (result_en) begin
                irq_o <= 1'b1;
                if (detect) begin
                    tof_o     <= tof_q;
                    timeout_o <= 1'b0;
                end else begin
                    tof_o     <= '1;
                    timeout_o <= 1'b1;
                end
            end
        end
    end

    // Config is captured only on an accepted start, so mid-ping changes are ignored.
    always_ff @(posedge clk) begin
        if (start_ok) begin
            burst_q  <= burst_cnt_i;
            half_q   <= half_per_i;
            blank_q  <= blank_i;
            listen_q <= listen_i;
        end
    end

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Self-checking bench for sonar_ping_sequencer. The expected behaviour of each
// ping comes from a timeline model: burst length, listen start and the first
// echo rise are computed from the config and the echo waveform.
module tb_sonar_ping_sequencer;

    localparam int CNT_W = 16;
    localparam int TOF_W = 24;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start_i = 1'b0;
    logic             abort_i = 1'b0;
    logic             echo_i = 1'b0;
    logic [CNT_W-1:0] burst_cnt_i = '0;
    logic [CNT_W-1:0] half_per_i = '0;
    logic [CNT_W-1:0] blank_i = '0;
    logic [CNT_W-1:0] listen_i = '0;
`ifdef PING_AUTO_REPEAT_EN
    logic             auto_i = 1'b0;
    logic [CNT_W-1:0] rep_gap_i = '0;
`endif
    logic             tx_o, dp_en_o, dp_clr_o, busy_o, done_o, timeout_o, irq_o;
    logic [TOF_W-1:0] tof_o;

    int checks = 0;
    int failures = 0;

    bit               wave [0:255];   // echo level indexed by cycles since ping start
    logic [TOF_W-1:0] m_tof = '0;     // model of the sticky result
    logic             m_to = 1'b0;

    sonar_ping_sequencer #(.CNT_W(CNT_W), .TOF_W(TOF_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start_i),
        .abort_i     (abort_i),
        .burst_cnt_i (burst_cnt_i),
        .half_per_i  (half_per_i),
        .blank_i     (blank_i),
        .listen_i    (listen_i),
`ifdef PING_AUTO_REPEAT_EN
        .auto_i      (auto_i),
        .rep_gap_i   (rep_gap_i),
`endif
        .echo_i      (echo_i),
        .tx_o        (tx_o),
        .dp_en_o     (dp_en_o),
        .dp_clr_o    (dp_clr_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .timeout_o   (timeout_o),
        .tof_o       (tof_o),
        .irq_o       (irq_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output vector order: {tx, dp_en, dp_clr, busy, done, irq}
    function automatic logic [31:0] outs();
        return {26'd0, tx_o, dp_en_o, dp_clr_o, busy_o, done_o, irq_o};
    endfunction

    task automatic set_wave(input int lo, input int hi, input bit v);
        for (int i = lo; i <= hi; i++) wave[i] = v;
    endtask

    task automatic rand_wave();
        bit v;
        v = 1'b0;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 5) == 0) v = ~v;
            wave[i] = v;
        end
    endtask

    // One ping. The model timeline is as follows.
    //   - tx is high in the even half-periods of the first 2*b*h cycles.
    //   - LISTEN starts at 2*b*h+bk and lasts max(l,1) cycles.
    //   - The ping completes one cycle after the first echo rise in LISTEN, or at window end.
    // inj_k: cycle at which a start and a cfg change are injected while busy.
    // abort_k: cycle at which abort_i is raised. A value of -1 disables either one.
    task automatic run_ping(input int b, input int h, input int bk, input int l,
                            input int inj_k, input int abort_k, input string tag);
        int he, bl, ls, ll, done_k;
        logic [TOF_W-1:0] e_tof;
        logic e_to;
        bit prev, e_tx, e_en;
        logic [31:0] e_vec;
        he = (h == 0) ? 1 : h;
        bl = 2 * b * he;
        ls = bl + bk;
        ll = (l == 0) ? 1 : l;
        done_k = -1;
        e_tof = '1;
        e_to = 1'b1;
        for (int t = ls; t < ls + ll; t++) begin
            prev = (t == 0) ? 1'b0 : wave[t-1];
            if (done_k < 0 && wave[t] && !prev) begin
                done_k = t + 1;
                e_tof = TOF_W'(t);
                e_to = 1'b0;
            end
        end
        if (done_k < 0) done_k = ls + ll;

        @(negedge clk);
        echo_i = 1'b0;
        burst_cnt_i = CNT_W'(b);
        half_per_i = CNT_W'(h);
        blank_i = CNT_W'(bk);
        listen_i = CNT_W'(l);
        start_i = 1'b1;
        for (int k = 0; k <= done_k + 1; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            echo_i = wave[k];
            if (abort_k >= 0 && k == abort_k + 1) begin
                abort_i = 1'b0;
                chk({tag, "/abort_outs"}, outs(), 32'd0);
                chk({tag, "/abort_tof"}, 32'(tof_o), 32'(m_tof));
                chk({tag, "/abort_to"}, 32'(timeout_o), 32'(m_to));
                @(negedge clk);
                chk({tag, "/abort_idle"}, outs(), 32'd0);
                return;
            end
            e_tx = (k < bl) && (((k / he) % 2) == 0);
            e_en = (k >= ls) && (k < done_k);
            e_vec = {26'd0, e_tx, e_en, k == ls, k <= done_k, k == done_k, k >= done_k};
            chk({tag, "/cyc"}, outs(), e_vec);
            if (k == done_k) begin
                chk({tag, "/tof"}, 32'(tof_o), 32'(e_tof));
                chk({tag, "/timeout"}, 32'(timeout_o), 32'(e_to));
                m_tof = e_tof;
                m_to = e_to;
            end
            if (k == inj_k) begin
                start_i = 1'b1;
                burst_cnt_i = CNT_W'($urandom_range(0, 5));
                half_per_i = CNT_W'($urandom_range(0, 5));
                blank_i = CNT_W'($urandom_range(0, 5));
                listen_i = CNT_W'($urandom_range(0, 5));
            end
            if (k == abort_k) abort_i = 1'b1;
        end
    endtask

    initial begin
        // Reset state
        #1;
        chk("reset/outs", outs(), 32'd0);
        chk("reset/tof", 32'(tof_o), 32'd0);
        chk("reset/timeout", 32'(timeout_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // T1: echo rises at tof=20
        set_wave(0, 255, 1'b0);
        set_wave(20, 255, 1'b1);
        run_ping(2, 3, 4, 50, -1, -1, "T1");
        chk("T1/tof_const", 32'(tof_o), 32'd20);
        chk("T1/irq", 32'(irq_o), 32'd1);

        // T2: no echo, timeout with done at tof=66
        set_wave(0, 255, 1'b0);
        run_ping(2, 3, 4, 50, -1, -1, "T2");
        chk("T2/tof_const", 32'(tof_o), 32'hFFFFFF);
        chk("T2/timeout_const", 32'(timeout_o), 32'd1);

        // T3: echo high on LISTEN entry (16), falls at 19, rises at 21
        set_wave(0, 255, 1'b0);
        set_wave(10, 18, 1'b1);
        set_wave(21, 255, 1'b1);
        run_ping(2, 3, 4, 50, -1, -1, "T3");
        chk("T3/tof_const", 32'(tof_o), 32'd21);

        // T4: abort mid-BURST keeps the previous result
        set_wave(0, 255, 1'b0);
        run_ping(2, 3, 4, 50, -1, 4, "T4");

        // T5: start and cfg change while busy are ignored
        set_wave(0, 255, 1'b0);
        set_wave(30, 255, 1'b1);
        run_ping(2, 3, 4, 50, 3, -1, "T5");
        @(negedge clk);
        start_i = 1'b1;
        abort_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        chk("T5/start_abort", outs(), 32'd1);
        @(negedge clk);
        chk("T5/still_idle", outs(), 32'd1);

        // T6: all-zero config gives an immediate timeout
        set_wave(0, 255, 1'b0);
        run_ping(0, 0, 0, 0, -1, -1, "T6");
        chk("T6/timeout_const", 32'(timeout_o), 32'd1);

        // Randomized pings
        for (int r = 0; r < 12; r++) begin
            rand_wave();
            run_ping(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                     int'($urandom_range(0, 6)), int'($urandom_range(0, 30)),
                     -1, -1, "RND");
        end

`ifdef PING_AUTO_REPEAT_EN
        // Auto repeat: done at k=1, GAP for 10 cycles, LISTEN re-entered at k=12
        set_wave(0, 255, 1'b0);
        auto_i = 1'b1;
        rep_gap_i = CNT_W'(10);
        @(negedge clk);
        burst_cnt_i = '0;
        half_per_i = '0;
        blank_i = '0;
        listen_i = '0;
        start_i = 1'b1;
        for (int k = 0; k <= 13; k++) begin
            @(negedge clk);
            start_i = 1'b0;
            chk("AUTO/busy", 32'(busy_o), 32'd1);
            chk("AUTO/clr", 32'(dp_clr_o), 32'((k == 0) || (k == 12)));
            chk("AUTO/done", 32'(done_o), 32'((k == 1) || (k == 13)));
        end
        auto_i = 1'b0;
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        chk("AUTO/abort", 32'(busy_o), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
